// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-width encodings as produced
// by the decoder, the FSM state encoding and the default ack timeout.
package lsu_pkg;

  // Access width (whb) encodings; 2'b11 is illegal.
  localparam logic [1:0] WHB_BYTE = 2'b00;
  localparam logic [1:0] WHB_HALF = 2'b01;
  localparam logic [1:0] WHB_WORD = 2'b10;

  // Cycles mem_req may wait for mem_ack before the access is aborted.
  localparam int unsigned LSU_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    FAULT
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   addr_i     low two address bits of the access
//   whb_i      access width (byte/half/word/illegal)
//   su_i       1 = sign-extend load, 0 = zero-extend
//   wdata_i    raw store data
//   rdata_i    raw memory read word
//   be_o       byte enables for the access
//   wdata_o    store data replicated across all lanes of its width
//   rdata_o    load data extracted from its lane and extended to 32 bits
//   misalign_o width is illegal or the address is not naturally aligned
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  whb_i,
  input  logic        su_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_v = rdata_i[{addr_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = rdata_i;
    misalign_o = 1'b0;
    unique case (whb_i)
      WHB_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{su_i & byte_v[7]}}, byte_v};
      end
      WHB_HALF: begin
        be_o       = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{su_i & half_v[15]}}, half_v};
        misalign_o = addr_i[0];
      end
      WHB_WORD: begin
        be_o       = 4'b1111;
        misalign_o = |addr_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one data-memory access per request over a req/ack
// handshake, with lane formatting, load extension, misalignment and timeout faults.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_valid/ex_ld/ex_st          request qualifiers from EX/MEM
//   ex_addr/ex_wdata/ex_whb/ex_su access address, store data, width, signedness
//   lsu_stall                     hold the pipeline (accept cycle and while busy)
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_ack/mem_rdata   memory port
//   wb_valid/wb_rdata             one-cycle completion pulse and load result
//   misalign/bus_err              one-cycle fault pulses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_ld,
  input  logic              ex_st,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [1:0]        ex_whb,
  input  logic              ex_su,
  output logic              lsu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_rdata,
  output logic              misalign,
  output logic              bus_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lo_q;
  logic [1:0]        whb_q;
  logic              su_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              mem_req_q;
  logic              wb_valid_q;
  logic [31:0]       wb_rdata_q;
  logic              misalign_q;
  logic              bus_err_q;

  logic              accept;
  logic              illegal;
  logic [1:0]        al_addr;
  logic [1:0]        al_whb;
  logic              al_su;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              al_misalign;

  // One aligner serves both phases: request fields while idle, latched fields while busy.
  assign al_addr = (state_q == BUSY) ? lo_q  : ex_addr[1:0];
  assign al_whb  = (state_q == BUSY) ? whb_q : ex_whb;
  assign al_su   = (state_q == BUSY) ? su_q  : ex_su;

  lsu_align u_align (
    .addr_i     (al_addr),
    .whb_i      (al_whb),
    .su_i       (al_su),
    .wdata_i    (ex_wdata),
    .rdata_i    (mem_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign)
  );

  assign accept  = (state_q == IDLE) && ex_valid && (ex_ld || ex_st);
  assign illegal = al_misalign || (ex_ld && ex_st);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      lo_q       <= 2'b00;
      whb_q      <= 2'b00;
      su_q       <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      mem_req_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rdata_q <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      // Pulse outputs default low; set only on the transition into their state.
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              state_q    <= FAULT;
              misalign_q <= 1'b1;
            end else begin
              state_q   <= BUSY;
              mem_req_q <= 1'b1;
              cnt_q     <= '0;
              addr_q    <= {ex_addr[ADDR_W-1:2], 2'b00};
              lo_q      <= ex_addr[1:0];
              whb_q     <= ex_whb;
              su_q      <= ex_su;
              we_q      <= ex_st;
              be_q      <= al_be;
              wdata_q   <= al_wdata;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_q    <= DONE;
            mem_req_q  <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_rdata_q <= we_q ? 32'h0 : al_rdata;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q   <= FAULT;
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          wb_rdata_q <= '0;
        end
        FAULT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_stall = accept || (state_q == BUSY);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_req_q & we_q;
  assign mem_addr  = mem_req_q ? addr_q  : '0;
  assign mem_be    = mem_req_q ? be_q    : 4'b0000;
  assign mem_wdata = mem_req_q ? wdata_q : 32'h0;
  assign wb_valid  = wb_valid_q;
  assign wb_rdata  = wb_rdata_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ld, ex_st, ex_su;
  logic [31:0] ex_addr, ex_wdata;
  logic [1:0]  ex_whb;
  logic        lsu_stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, misalign, bus_err;
  logic [31:0] wb_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_ld     (ex_ld),
    .ex_st     (ex_st),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_whb    (ex_whb),
    .ex_su     (ex_su),
    .lsu_stall (lsu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_rdata  (wb_rdata),
    .misalign  (misalign),
    .bus_err   (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference behaviour from the access rules: size in bytes, natural alignment,
  // byte-enable mask, replicated store lanes and shifted/masked/extended load data.
  function automatic void model(input logic ld, input logic st, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic [1:0] whb, input logic su,
                                output logic illegal, output logic [3:0] be,
                                output logic [31:0] lanes, output logic [31:0] res);
    int a;
    int size;
    logic [31:0] mask, v;
    a = int'(addr[1:0]);
    size = (whb == 2'd0) ? 1 : (whb == 2'd1) ? 2 : 4;
    illegal = (ld && st) || (whb == 2'd3) || ((a % size) != 0);
    be = 4'(((1 << size) - 1) << a);
    if (size == 1) lanes = {24'h0, wd[7:0]} * 32'h0101_0101;
    else if (size == 2) lanes = {16'h0, wd[15:0]} * 32'h0001_0001;
    else lanes = wd;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v = (rd >> (8 * a)) & mask;
    if (su && size < 4 && ((v >> (8 * size - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    res = st ? 32'h0 : v;
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_ld = 1'b0; ex_st = 1'b0;
  endtask

  // One request end to end; delay >= TIMEOUT means memory never acks.
  task automatic run_op(input string nm, input logic ld, input logic st,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] whb, input logic su,
                        input int delay, input logic [31:0] rd);
    logic        ill;
    logic [3:0]  ebe;
    logic [31:0] elanes, eres;
    int          ncyc;
    model(ld, st, addr, wd, rd, whb, su, ill, ebe, elanes, eres);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_ld = ld; ex_st = st; ex_addr = addr;
    ex_wdata = wd; ex_whb = whb; ex_su = su;
    @(negedge clk);
    check({nm, ".stall_accept"}, 32'(lsu_stall), 32'd1);
    check({nm, ".req_accept"}, 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    if (ill) begin
      @(negedge clk);
      check({nm, ".misalign"}, 32'(misalign), 32'd1);
      check({nm, ".noreq"}, 32'(mem_req), 32'd0);
      check({nm, ".stall_fault"}, 32'(lsu_stall), 32'd0);
      check({nm, ".wbv_fault"}, 32'(wb_valid), 32'd0);
    end else begin
      ncyc = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
      for (int i = 0; i < ncyc; i++) begin
        mem_ack   = (i == delay);
        mem_rdata = (i == delay) ? rd : $urandom;
        @(negedge clk);
        check({nm, ".req"}, 32'(mem_req), 32'd1);
        check({nm, ".we"}, 32'(mem_we), 32'(st));
        check({nm, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        check({nm, ".be"}, 32'(mem_be), 32'(ebe));
        check({nm, ".stall_busy"}, 32'(lsu_stall), 32'd1);
        if (st) check({nm, ".wdata"}, mem_wdata, elanes);
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
      @(negedge clk);
      check({nm, ".req_end"}, 32'(mem_req), 32'd0);
      check({nm, ".stall_end"}, 32'(lsu_stall), 32'd0);
      if (delay < TIMEOUT) begin
        check({nm, ".wb_valid"}, 32'(wb_valid), 32'd1);
        check({nm, ".wb_rdata"}, wb_rdata, eres);
        check({nm, ".no_buserr"}, 32'(bus_err), 32'd0);
      end else begin
        check({nm, ".bus_err"}, 32'(bus_err), 32'd1);
        check({nm, ".wbv_timeout"}, 32'(wb_valid), 32'd0);
      end
    end
    // Pulses last exactly one cycle and the unit is back in IDLE.
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, ".pulse_wbv"}, 32'(wb_valid), 32'd0);
    check({nm, ".pulse_mis"}, 32'(misalign), 32'd0);
    check({nm, ".pulse_err"}, 32'(bus_err), 32'd0);
    check({nm, ".idle_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    ex_addr = '0; ex_wdata = '0; ex_whb = 2'b00; ex_su = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset.req", 32'(mem_req), 32'd0);
    check("reset.stall", 32'(lsu_stall), 32'd0);
    check("reset.wbv", 32'(wb_valid), 32'd0);
    check("reset.wbr", wb_rdata, 32'd0);
    check("reset.flags", {30'd0, misalign, bus_err}, 32'd0);

    run_op("lb_signed", 1, 0, 32'h103, 32'h0, 2'b00, 1, 0, 32'h80AA_BBCC);
    run_op("lhu", 1, 0, 32'h202, 32'h0, 2'b01, 0, 0, 32'h8001_1234);
    run_op("sb_delay", 0, 1, 32'h301, 32'h1234_56A5, 2'b00, 0, 3, 32'hDEAD_BEEF);
    run_op("lw_mis", 1, 0, 32'h402, 32'h0, 2'b10, 0, 0, 32'h0);
    run_op("whb11", 1, 0, 32'h400, 32'h0, 2'b11, 0, 0, 32'h0);
    run_op("ld_st", 1, 1, 32'h400, 32'h0, 2'b10, 0, 0, 32'h0);
    run_op("lw_timeout", 1, 0, 32'h500, 32'h0, 2'b10, 0, TIMEOUT, 32'h0);
    run_op("lw_lastack", 1, 0, 32'h504, 32'h0, 2'b10, 0, TIMEOUT - 1, 32'h1357_9BDF);

    // Reset in the middle of a busy access, then a stray ack.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_ld = 1'b1; ex_addr = 32'h600; ex_whb = 2'b10; ex_su = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rst_mid.busy_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rst_mid.req", 32'(mem_req), 32'd0);
    check("rst_mid.bus", {mem_we, mem_be, 27'd0} | mem_addr | mem_wdata, 32'd0);
    check("rst_mid.wb", {31'd0, wb_valid} | wb_rdata, 32'd0);
    check("rst_mid.flags", {29'd0, lsu_stall, misalign, bus_err}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rst_mid.late_ack", {30'd0, wb_valid, mem_req}, 32'd0);
    run_op("after_rst", 1, 0, 32'h702, 32'h0, 2'b01, 1, 1, 32'h9ABC_0000);

    // Randomized requests checked against the reference model.
    for (int k = 0; k < 24; k++) begin
      logic [1:0] w;
      logic ld, st, both;
      w = 2'($urandom_range(0, 3));
      both = ($urandom_range(0, 9) == 0);
      st = both ? 1'b1 : 1'($urandom_range(0, 1));
      ld = both ? 1'b1 : ~st;
      run_op($sformatf("rnd%0d", k), ld, st, $urandom, $urandom, w,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Consumes the width/sign controls that the decoder produces: whb (00 byte, 01 half, 10 word) and su (1 signed, 0 unsigned).
- Performs one data-memory load or store per request over a req/ack memory handshake.
- Generates byte enables, replicates store data across lanes, and extracts and sign/zero-extends load data.
- Sits in the MEM stage between the EX/MEM pipeline register and the data memory; stalls the pipeline while an access is in flight.

Parameters:
- TIMEOUT, 16: maximum cycles mem_req may wait for mem_ack before the access is aborted with bus_err.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  MEM-stage instruction valid
- ex_ld  in  1  load instruction
- ex_st  in  1  store instruction
- ex_addr  in  ADDR_W  effective address from ALU
- ex_wdata  in  32  store data (rs2)
- ex_whb  in  2  access width: 00 byte, 01 half, 10 word, 11 illegal
- ex_su  in  1  1 = sign-extend load, 0 = zero-extend
- lsu_stall  out  1  hold pipeline
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address ({ex_addr[ADDR_W-1:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion (read data valid with it)
- mem_rdata  in  32  memory read word
- wb_valid  out  1  one-cycle completion pulse
- wb_rdata  out  32  extended load result (0 for stores)
- misalign  out  1  one-cycle pulse: misaligned or illegal request, no memory access
- bus_err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. Reset mid-access returns to IDLE; mem_req is low from the cycle after the reset edge, and a late mem_ack is ignored.
- States: IDLE, BUSY, DONE, FAULT.
- IDLE accepts a request when ex_valid & (ex_ld | ex_st).
  - Illegal request: ex_whb == 11, or ex_ld & ex_st, or half with addr[0] != 0, or word with addr[1:0] != 0. Next state FAULT.
  - Otherwise latch addr, whb, su, we = ex_st, formatted wdata and be. Next state BUSY.
- BUSY:
  - mem_req = 1, with mem_we/mem_addr/mem_be/mem_wdata stable until the ack.
  - On mem_ack: capture the formatted load result and go to DONE.
  - Otherwise the counter increments; when it reaches TIMEOUT-1 without ack, go to FAULT with a bus_err cause.
- DONE: wb_valid = 1 for one cycle; wb_rdata holds the result (stores: 0). Always returns to IDLE. No new request is accepted in DONE.
- FAULT: misalign = 1 or bus_err = 1 for one cycle per cause; wb_valid = 0. Returns to IDLE.
- lsu_stall = 1 in the IDLE accept cycle and in BUSY. It is 0 in DONE and FAULT so the pipeline advances exactly once per request.
- Minimum load/store latency: accept cycle T, mem_req at T+1, ack at T+1 at the earliest, wb_valid at T+2.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Load extraction:
  - byte = rdata[8*addr[1:0] +: 8]
  - half = rdata[16*addr[1] +: 16]
  - Extend to 32 bits with the MSB if su = 1, with 0 if su = 0; word ignores su.
- mem_ack outside BUSY is ignored.
- The counter clears on entry to BUSY.

Decomposition:
- Package lsu_pkg holds:
  - whb encodings WHB_BYTE/WHB_HALF/WHB_WORD
  - state encoding IDLE/BUSY/DONE/FAULT
  - the default TIMEOUT
- One combinational sub-module, lsu_align: inputs addr[1:0], whb, su, wdata, rdata; outputs be, store lanes, extended load data and the misalign flag. The FSM, counter and output registers stay in load_store_unit.

Test Plan:
- Load byte, address 0x103, su = 1. Memory returns 0x80AA_BBCC with ack on the first BUSY cycle. Required: mem_addr = 0x100, be = 1000, wb_rdata = 0xFFFFFF80, wb_valid at T+2.
- Load half unsigned, address 0x202; rdata = 0x8001_1234. Required: be = 1100, wb_rdata = 0x00008001.
- Store byte, address 0x301, wdata = 0x1234_56A5, ack delayed 3 cycles. Required: mem_we = 1, be = 0010, mem_wdata = 0xA5A5A5A5 stable for 4 req cycles, lsu_stall high throughout, wb_valid then wb_rdata = 0.
- Load word at 0x402. Required: no mem_req, misalign pulse at T+1, lsu_stall low at T+1. Repeat with whb = 11, and with ex_ld = ex_st = 1: same result.
- Load word with no ack. Required: mem_req high for TIMEOUT (16) cycles, then a bus_err pulse, wb_valid never asserted, return to IDLE.
- Assert rst during BUSY, then drive mem_ack after reset. Required: all outputs 0, no wb_valid, and the next request completes normally.
